// File: rtl/servo_shutter_pkg.sv
// servo_shutter_pkg
// Shared definitions for the multi-channel servo shutter controller:
// the per-channel FSM state encoding, direction constants and the
// default servo codes used as parameter defaults by the top level.

package servo_shutter_pkg;

    // Per-channel shutter state. HOME is only ever entered from reset.
    typedef enum logic [1:0] {
        ST_HOME   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DRV_UP = 2'd2,
        ST_DRV_DN = 2'd3
    } state_t;

    // Direction encoding shared by the dir inputs and last_dir outputs.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Default servo codes: full speed up, motor stopped, full speed down.
    localparam logic [7:0] POS_UP_DEF   = 8'hFF;
    localparam logic [7:0] POS_HALT_DEF = 8'h50;
    localparam logic [7:0] POS_DOWN_DEF = 8'h0F;

endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch
// One RC-servo PWM channel. The servo code is captured at the start of
// every frame so the pulse width can only change on a frame boundary.
//
// Ports:
//   clk_50      in   system clock
//   reset       in   asynchronous, active-low reset
//   frame_cnt   in   shared frame counter, 0..FRAME_CYC-1
//   frame_start in   high while frame_cnt == 0
//   pos         in   current servo code for this channel
//   pwm         out  registered servo pulse

module servo_pwm_ch
    import servo_shutter_pkg::*;
#(
    parameter int PULSE_MIN  = 50000,
    parameter int PULSE_STEP = 196
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic [31:0] frame_cnt,
    input  logic        frame_start,
    input  logic [7:0]  pos,
    output logic        pwm
);

    logic [7:0]  pos_lat;
    logic [7:0]  code;
    logic [31:0] width;

    // On the frame-start cycle the fresh code is used directly, so the
    // first pulse cycle of a frame already reflects the newly latched value.
    assign code  = frame_start ? pos : pos_lat;
    assign width = 32'(PULSE_MIN) + 32'(code) * 32'(PULSE_STEP);

    // Latch the code at the frame boundary and register the comparator
    // output, giving exactly 'width' high cycles per frame.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            pos_lat <= '0;
            pwm     <= 1'b0;
        end else begin
            if (frame_start) begin
                pos_lat <= pos;
            end
            pwm <= (frame_cnt < width);
        end
    end

endmodule

// File: rtl/servo_shutter_array.sv
// servo_shutter_array
// N-channel servo shutter controller. Each channel homes after reset,
// then drives its servo up or down for about WAIT_MS milliseconds whenever
// a direction change is requested. A shared ms tick and a shared 20 ms
// PWM frame counter serve all channels.
//
// Optional build macro: SERVO_SHUTTER_LIMIT_EN adds the 'limit' input
// (active-high end-stop switches) which ends a move early.
//
// Ports:
//   clk_50    in   50 MHz system clock
//   reset     in   asynchronous, active-low reset
//   go        in   per-channel move enable (level)
//   dir       in   per-channel requested direction, 1=up, 0=down
//   limit     in   per-channel end-stop (only with SERVO_SHUTTER_LIMIT_EN)
//   pwm       out  servo pulse outputs
//   pos_out   out  current servo code, channel i at [8i+7:8i]
//   busy      out  channel is homing or driving
//   last_dir  out  last direction driven
//   ms_tick   out  one-cycle ms strobe

module servo_shutter_array
    import servo_shutter_pkg::*;
#(
    parameter int         N_CH       = 4,
    parameter int         MS_DIV     = 50000,
    parameter int         WAIT_MS    = 4,
    parameter int         T_W        = 12,
    parameter logic [7:0] POS_UP     = POS_UP_DEF,
    parameter logic [7:0] POS_HALT   = POS_HALT_DEF,
    parameter logic [7:0] POS_DOWN   = POS_DOWN_DEF,
    parameter int         FRAME_CYC  = 1000000,
    parameter int         PULSE_MIN  = 50000,
    parameter int         PULSE_STEP = 196
) (
    input  logic                clk_50,
    input  logic                reset,
    input  logic [N_CH-1:0]     go,
    input  logic [N_CH-1:0]     dir,
`ifdef SERVO_SHUTTER_LIMIT_EN
    input  logic [N_CH-1:0]     limit,
`endif
    output logic [N_CH-1:0]     pwm,
    output logic [8*N_CH-1:0]   pos_out,
    output logic [N_CH-1:0]     busy,
    output logic [N_CH-1:0]     last_dir,
    output logic                ms_tick
);

    localparam logic [T_W-1:0] WAIT_T = T_W'(WAIT_MS);

    logic [31:0]     tick_cnt;
    logic [31:0]     frame_cnt;
    logic            frame_start;
    logic [N_CH-1:0] limit_sync;

    // Free-running ms tick generator; the strobe is high on the cycle
    // after the counter wraps back to zero.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            ms_tick  <= 1'b0;
        end else if (tick_cnt == 32'(MS_DIV - 1)) begin
            tick_cnt <= '0;
            ms_tick  <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
            ms_tick  <= 1'b0;
        end
    end

    // Shared PWM frame counter; every channel aligns its pulse to it.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_cnt == 32'(FRAME_CYC - 1)) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 32'd1;
        end
    end

    assign frame_start = (frame_cnt == 32'd0);

`ifdef SERVO_SHUTTER_LIMIT_EN
    logic [N_CH-1:0] limit_meta;

    // End-stop switches are asynchronous to clk_50: two-flop synchroniser.
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            limit_meta <= '0;
            limit_sync <= '0;
        end else begin
            limit_meta <= limit;
            limit_sync <= limit_meta;
        end
    end
`else
    assign limit_sync = '0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t         state, state_nxt;
        logic [T_W-1:0] timer, timer_nxt;
        logic [7:0]     pos, pos_nxt;
        logic           busy_q, busy_nxt;
        logic           last_q, last_nxt;

        // Channel state and all channel outputs are registered together.
        always_ff @(posedge clk_50 or negedge reset) begin
            if (!reset) begin
                state  <= ST_HOME;
                timer  <= '0;
                pos    <= POS_HALT;
                busy_q <= 1'b0;
                last_q <= DIR_UP;
            end else begin
                state  <= state_nxt;
                timer  <= timer_nxt;
                pos    <= pos_nxt;
                busy_q <= busy_nxt;
                last_q <= last_nxt;
            end
        end

        // Next-state logic. Timed states end one clock after the timer
        // reaches WAIT_MS; the timer never counts past that value.
        always_comb begin
            state_nxt = state;
            timer_nxt = timer;
            pos_nxt   = pos;
            busy_nxt  = busy_q;
            last_nxt  = last_q;
            case (state)
                ST_HOME: begin
                    pos_nxt  = POS_DOWN;
                    busy_nxt = 1'b1;
                    if (limit_sync[i]) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                        pos_nxt   = POS_HALT;
                        busy_nxt  = 1'b0;
                    end else if (timer == WAIT_T) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                        pos_nxt   = POS_HALT;
                        busy_nxt  = 1'b0;
                        last_nxt  = DIR_DN;
                    end else if (ms_tick) begin
                        timer_nxt = timer + T_W'(1);
                    end
                end
                ST_IDLE: begin
                    pos_nxt   = POS_HALT;
                    busy_nxt  = 1'b0;
                    timer_nxt = '0;
                    if (go[i] && (dir[i] != last_q)) begin
                        state_nxt = (dir[i] == DIR_UP) ? ST_DRV_UP : ST_DRV_DN;
                        pos_nxt   = (dir[i] == DIR_UP) ? POS_UP : POS_DOWN;
                        busy_nxt  = 1'b1;
                        last_nxt  = dir[i];
                    end
                end
                ST_DRV_UP, ST_DRV_DN: begin
                    if (limit_sync[i] || (timer == WAIT_T)) begin
                        state_nxt = ST_IDLE;
                        timer_nxt = '0;
                        pos_nxt   = POS_HALT;
                        busy_nxt  = 1'b0;
                    end else if (ms_tick) begin
                        timer_nxt = timer + T_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_HOME;
                    timer_nxt = '0;
                end
            endcase
        end

        assign pos_out[8*i +: 8] = pos;
        assign busy[i]           = busy_q;
        assign last_dir[i]       = last_q;

        servo_pwm_ch #(
            .PULSE_MIN  (PULSE_MIN),
            .PULSE_STEP (PULSE_STEP)
        ) u_pwm (
            .clk_50      (clk_50),
            .reset       (reset),
            .frame_cnt   (frame_cnt),
            .frame_start (frame_start),
            .pos         (pos),
            .pwm         (pwm[i])
        );
    end

endmodule

// File: tb/tb_servo_shutter_array.sv
// tb_servo_shutter_array
// Self-checking bench for servo_shutter_array (default build, no limit
// input). The reference model works from edge timestamps: each move's end
// edge is computed arithmetically from the tick period, and the PWM level
// from the frame position and the code captured at the frame start.

module tb_servo_shutter_array;

    localparam int N          = 4;
    localparam int MS_DIV     = 10;
    localparam int WAIT_MS    = 4;
    localparam int FRAME_CYC  = 1000;
    localparam int PULSE_MIN  = 100;
    localparam int PULSE_STEP = 1;
    localparam logic [7:0] P_UP   = 8'hFF;
    localparam logic [7:0] P_HALT = 8'h50;
    localparam logic [7:0] P_DOWN = 8'h0F;

    logic             clk_50;
    logic             reset;
    logic [N-1:0]     go;
    logic [N-1:0]     dir;
    logic [N-1:0]     pwm;
    logic [8*N-1:0]   pos_out;
    logic [N-1:0]     busy;
    logic [N-1:0]     last_dir;
    logic             ms_tick;

    int tests_run;
    int tests_failed;

    // Reference model state
    int         k;
    int         m_end    [N];
    bit         m_active [N];
    bit         m_homing [N];
    logic [7:0] m_pos    [N];
    logic [7:0] m_lat    [N];
    bit         m_busy   [N];
    bit         m_last   [N];
    bit         m_pwm    [N];
    bit         m_tick;

    servo_shutter_array #(
        .N_CH       (N),
        .MS_DIV     (MS_DIV),
        .WAIT_MS    (WAIT_MS),
        .T_W        (12),
        .POS_UP     (P_UP),
        .POS_HALT   (P_HALT),
        .POS_DOWN   (P_DOWN),
        .FRAME_CYC  (FRAME_CYC),
        .PULSE_MIN  (PULSE_MIN),
        .PULSE_STEP (PULSE_STEP)
    ) dut (
        .clk_50   (clk_50),
        .reset    (reset),
        .go       (go),
        .dir      (dir),
        .pwm      (pwm),
        .pos_out  (pos_out),
        .busy     (busy),
        .last_dir (last_dir),
        .ms_tick  (ms_tick)
    );

    initial clk_50 = 1'b0;
    always #10 clk_50 = ~clk_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h",
                     tag, k, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] go_v, input logic [N-1:0] dir_v);
        go  = go_v;
        dir = dir_v;
    endtask

    task automatic modelReset();
        k = 0;
        m_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_active[i] = 1'b1;
            m_homing[i] = 1'b1;
            m_end[i]    = WAIT_MS * MS_DIV + 1;
            m_pos[i]    = P_HALT;
            m_lat[i]    = 8'h00;
            m_busy[i]   = 1'b0;
            m_last[i]   = 1'b1;
            m_pwm[i]    = 1'b0;
        end
    endtask

    // Advance the model across one rising edge, using the inputs held at it.
    task automatic modelEdge();
        int fc;
        int f1;
        fc = k % FRAME_CYC;
        m_tick = ((k + 1) % MS_DIV == 0);
        for (int i = 0; i < N; i++) begin
            if (fc == 0) m_lat[i] = m_pos[i];
            m_pwm[i] = (fc < PULSE_MIN + int'(m_lat[i]) * PULSE_STEP);
            if (m_active[i]) begin
                if (k == m_end[i]) begin
                    m_active[i] = 1'b0;
                    m_pos[i]    = P_HALT;
                    m_busy[i]   = 1'b0;
                    if (m_homing[i]) m_last[i] = 1'b0;
                    m_homing[i] = 1'b0;
                end else if (m_homing[i]) begin
                    m_pos[i]  = P_DOWN;
                    m_busy[i] = 1'b1;
                end
            end else if (go[i] && (dir[i] != m_last[i])) begin
                m_active[i] = 1'b1;
                m_busy[i]   = 1'b1;
                m_last[i]   = dir[i];
                m_pos[i]    = dir[i] ? P_UP : P_DOWN;
                f1          = (k / MS_DIV + 1) * MS_DIV;
                m_end[i]    = f1 + (WAIT_MS - 1) * MS_DIV + 1;
            end
        end
        k++;
    endtask

    task automatic compareAll();
        logic [8*N-1:0] e_pos;
        logic [N-1:0]   e_busy, e_last, e_pwm;
        for (int i = 0; i < N; i++) begin
            e_pos[8*i +: 8] = m_pos[i];
            e_busy[i]       = m_busy[i];
            e_last[i]       = m_last[i];
            e_pwm[i]        = m_pwm[i];
        end
        checkOutput("pos_out",  32'(pos_out),  32'(e_pos));
        checkOutput("busy",     32'(busy),     32'(e_busy));
        checkOutput("last_dir", 32'(last_dir), 32'(e_last));
        checkOutput("pwm",      32'(pwm),      32'(e_pwm));
        checkOutput("ms_tick",  32'(ms_tick),  32'(m_tick));
    endtask

    task automatic runCycles(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            if (rnd && ($urandom_range(0, 7) == 0)) begin
                applyStimulus(N'($urandom), N'($urandom));
            end
            @(posedge clk_50);
            modelEdge();
            @(negedge clk_50);
            compareAll();
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pos"},   32'(pos_out),  32'({N{P_HALT}}));
        checkOutput({tag, "_busy"},  32'(busy),     32'(0));
        checkOutput({tag, "_last"},  32'(last_dir), 32'({N{1'b1}}));
        checkOutput({tag, "_pwm"},   32'(pwm),      32'(0));
        checkOutput({tag, "_tick"},  32'(ms_tick),  32'(0));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        applyStimulus('0, '0);
        modelReset();
        repeat (3) @(negedge clk_50);
        checkResetValues("por");
        reset = 1'b1;

        // Homing, then directed moves on channels 0 and 1
        runCycles(50, 1'b0);
        applyStimulus(4'b0001, 4'b0001);
        runCycles(60, 1'b0);
        applyStimulus(4'b0011, 4'b0011);
        runCycles(10, 1'b0);
        applyStimulus(4'b0011, 4'b0001);
        runCycles(80, 1'b0);

        // Random traffic across several PWM frames
        runCycles(3000, 1'b1);

        // Reset in the middle of activity
        applyStimulus(4'b1111, 4'b1010);
        runCycles(3, 1'b0);
        reset = 1'b0;
        #1;
        checkResetValues("mid_rst");
        modelReset();
        repeat (2) @(negedge clk_50);
        checkResetValues("mid_hold");
        reset = 1'b1;
        runCycles(2500, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
